// File: rtl/gpio_bank_ctrl.sv
// GPIO bank: OUT/OE control registers, synchronised + debounced inputs,
// per-pin rise/fall interrupts with sticky W1C status and a level irq.
// Ports: clk, rst (async, active high); gpio_in/gpio_out/gpio_oe pin side;
//   wr_en, rd_en, addr, wr_data, rd_data, rd_valid register bus; irq.
module gpio_bank_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             irq
);

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_OE   = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_STS  = 3'd5;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] filt_q;
  logic [WIDTH-1:0] filt_dly_q;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rise, fall, w1c;
  logic             rd_valid_q;
  logic             irq_q;

  // Synchroniser chain; the last stage feeds the debouncer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE > 0) begin : g_deb
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         filt_d;

    // Any return to the filtered value restarts the count, so short
    // glitches never reach filt_q.
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          filt_d[i] = s[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        filt_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end
  end else begin : g_byp
    always_ff @(posedge clk or posedge rst) begin
      if (rst) filt_q <= '0;
      else     filt_q <= s;
    end
  end

  assign rise = filt_q & ~filt_dly_q & rise_en_q;
  assign fall = ~filt_q & filt_dly_q & fall_en_q;
  assign w1c  = (wr_en && addr == A_STS) ? wr_data : '0;

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:   rd_mux = out_q;
      A_OE:    rd_mux = oe_q;
      A_IN:    rd_mux = filt_q;
      A_RISE:  rd_mux = rise_en_q;
      A_FALL:  rd_mux = fall_en_q;
      A_STS:   rd_mux = status_q;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr_en) begin
      case (addr)
        A_OUT:   out_d     = wr_data;
        A_OE:    oe_d      = wr_data;
        A_RISE:  rise_en_d = wr_data;
        A_FALL:  fall_en_d = wr_data;
        default: ;
      endcase
    end
    // New edges override a simultaneous clear.
    status_d  = (status_q & ~w1c) | rise | fall;
    // Read mux samples pre-write state, so a same-cycle RW reads old data.
    rd_data_d = rd_en ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      oe_q       <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      filt_dly_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      oe_q       <= oe_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      filt_dly_q <= filt_q;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      irq_q      <= |status_q;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Self-checking bench for gpio_bank_ctrl (WIDTH=32, SYNC=2, DEBOUNCE=4).
// Register vectors from a table; read data checked through a scoreboard.
module tb_gpio_bank_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  gpio_bank_ctrl #(
    .WIDTH(32),
    .SYNC_STAGES(2),
    .DEBOUNCE(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .addr(addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] rexp;
    logic [31:0] out_e;
    logic [31:0] oe_e;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] v;
    string       nm;
  } sb_t;

  sb_t  sb[$];
  vec_t tv[15];
  int   checks;
  int   errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock; read data is popped whenever the DUT flags it valid.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got %h expected none", rd_data);
      end else begin
        e = sb.pop_front();
        chk(e.nm, rd_data, e.v);
      end
    end
  endtask

  task automatic bus(input logic we, input logic re, input logic [2:0] a,
                     input logic [31:0] wd, input logic [31:0] exp,
                     input string nm);
    sb_t e;
    wr_en   = we;
    rd_en   = re;
    addr    = a;
    wr_data = wd;
    if (re) begin
      e.v  = exp;
      e.nm = nm;
      sb.push_back(e);
    end
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic re,
                              input logic [2:0] a, input logic [31:0] wd,
                              input logic [31:0] rexp,
                              input logic [31:0] out_e,
                              input logic [31:0] oe_e, input string nm);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.wd = wd; v.rexp = rexp;
    v.out_e = out_e; v.oe_e = oe_e; v.nm = nm;
    return v;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    gpio_in = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wr_data = '0;

    tv[0]  = mk(1, 0, 0, 32'hA5A5_0001, 0, 32'hA5A5_0001, 0, "wr_out");
    tv[1]  = mk(1, 0, 1, 32'hFFFF_0000, 0, 32'hA5A5_0001,
                32'hFFFF_0000, "wr_oe");
    tv[2]  = mk(0, 1, 0, 0, 32'hA5A5_0001, 32'hA5A5_0001,
                32'hFFFF_0000, "rd_out");
    tv[3]  = mk(0, 1, 1, 0, 32'hFFFF_0000, 32'hA5A5_0001,
                32'hFFFF_0000, "rd_oe");
    tv[4]  = mk(1, 0, 3, 32'h8, 0, 32'hA5A5_0001, 32'hFFFF_0000, "wr_rise");
    tv[5]  = mk(0, 1, 3, 0, 32'h8, 32'hA5A5_0001, 32'hFFFF_0000, "rd_rise");
    tv[6]  = mk(1, 0, 4, 32'h1, 0, 32'hA5A5_0001, 32'hFFFF_0000, "wr_fall");
    tv[7]  = mk(0, 1, 4, 0, 32'h1, 32'hA5A5_0001, 32'hFFFF_0000, "rd_fall");
    tv[8]  = mk(1, 0, 6, 32'hFFFF_FFFF, 0, 32'hA5A5_0001,
                32'hFFFF_0000, "wr_rsv6");
    tv[9]  = mk(0, 1, 6, 0, 0, 32'hA5A5_0001, 32'hFFFF_0000, "rd_rsv6");
    tv[10] = mk(0, 1, 7, 0, 0, 32'hA5A5_0001, 32'hFFFF_0000, "rd_rsv7");
    tv[11] = mk(1, 1, 1, 32'h1234_5678, 32'hFFFF_0000, 32'hA5A5_0001,
                32'h1234_5678, "rw_oe_old");
    tv[12] = mk(0, 1, 1, 0, 32'h1234_5678, 32'hA5A5_0001,
                32'h1234_5678, "rd_oe_new");
    tv[13] = mk(0, 1, 2, 0, 0, 32'hA5A5_0001, 32'h1234_5678, "rd_in_idle");
    tv[14] = mk(0, 1, 5, 0, 0, 32'hA5A5_0001, 32'h1234_5678, "rd_sts_idle");

    #1;
    chk("rst_out", gpio_out, 0);
    chk("rst_oe", gpio_oe, 0);
    chk("rst_rdv", {31'd0, rd_valid}, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    foreach (tv[i]) begin
      bus(tv[i].we, tv[i].re, tv[i].a, tv[i].wd, tv[i].rexp, tv[i].nm);
      chk({tv[i].nm, "_pin_out"}, gpio_out, tv[i].out_e);
      chk({tv[i].nm, "_pin_oe"}, gpio_oe, tv[i].oe_e);
    end
    tick();
    chk("rd_valid_low", {31'd0, rd_valid}, 0);

    // Three-cycle glitch on pin 3 must be filtered.
    gpio_in[3] = 1'b1;
    repeat (3) tick();
    gpio_in[3] = 1'b0;
    repeat (10) tick();
    bus(0, 1, 2, 0, 0, "glitch_in");
    tick();
    chk("glitch_irq", {31'd0, irq}, 0);

    // Held high: filt updates on edge 6, status on 7, irq on 8.
    gpio_in[3] = 1'b1;
    repeat (5) tick();
    bus(0, 1, 2, 0, 0, "in_edge6");
    bus(0, 1, 2, 0, 32'h8, "in_edge7");
    chk("irq_edge7", {31'd0, irq}, 0);
    tick();
    chk("irq_edge8", {31'd0, irq}, 1);
    bus(0, 1, 5, 0, 32'h8, "sts_rise3");

    // W1C: status clears at once, irq one edge later.
    bus(1, 0, 5, 32'h8, 0, "w1c");
    chk("irq_w1c_hold", {31'd0, irq}, 1);
    tick();
    chk("irq_w1c_drop", {31'd0, irq}, 0);
    bus(0, 1, 5, 0, 0, "sts_cleared");

    // Pin 0 falls on the same edge as a W1C of bit 0: set wins.
    gpio_in[0] = 1'b1;
    repeat (10) tick();
    bus(0, 1, 5, 0, 0, "sts_no_rise0");
    gpio_in[0] = 1'b0;
    repeat (6) tick();
    bus(1, 0, 5, 32'h1, 0, "w1c_race");
    bus(0, 1, 5, 0, 32'h1, "sts_set_wins");
    chk("irq_fall", {31'd0, irq}, 1);
    bus(1, 0, 4, 0, 0, "fall_dis");
    bus(0, 1, 5, 0, 32'h1, "sts_pending");

    // Asynchronous reset while read data is valid and irq is high.
    bus(0, 1, 0, 0, 32'hA5A5_0001, "rd_pre_rst");
    rst = 1'b1;
    #1;
    chk("mid_rst_out", gpio_out, 0);
    chk("mid_rst_oe", gpio_oe, 0);
    chk("mid_rst_irq", {31'd0, irq}, 0);
    chk("mid_rst_rdv", {31'd0, rd_valid}, 0);
    gpio_in = '0;
    tick();
    tick();
    rst = 1'b0;
    bus(0, 1, 0, 0, 0, "post_rst_out");
    bus(0, 1, 1, 0, 0, "post_rst_oe");
    bus(0, 1, 2, 0, 0, "post_rst_in");
    bus(0, 1, 5, 0, 0, "post_rst_sts");
    tick();
    chk("post_rst_irq", {31'd0, irq}, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
